// File: rtl/viewport_pkg.sv
// viewport_pkg: shared keycodes, camera FSM states and direction type for the scrolling viewport.
package viewport_pkg;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;

    typedef enum logic [1:0] {CAM_IDLE, CAM_SLOW, CAM_FAST} cam_state_t;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } dir_t;
endpackage

// File: rtl/viewport_camera.sv
// viewport_camera: keycode-driven camera with accelerating slow/fast scroll FSM.
// SCROLL_WRAP_EN selects modulo wrap of the camera instead of clamping.
module viewport_camera
    import viewport_pkg::*;
#(
    parameter int MAP_W       = 480,
    parameter int MAP_H       = 320,
    parameter int VIEW_W      = 240,
    parameter int VIEW_H      = 160,
    parameter int SLOW_STEP   = 1,
    parameter int FAST_STEP   = 4,
    parameter int HOLD_FRAMES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_i,
    input  logic [15:0] keycode_i,
    output logic [9:0]  cam_x_o,
    output logic [9:0]  cam_y_o
);
    localparam int CW = $clog2(HOLD_FRAMES + 1);
`ifdef SCROLL_WRAP_EN
    localparam int LIM_X = MAP_W;
    localparam int LIM_Y = MAP_H;
`else
    localparam int LIM_X = MAP_W - VIEW_W;
    localparam int LIM_Y = MAP_H - VIEW_H;
`endif

    cam_state_t         state_q;
    logic [CW-1:0]      cnt_q;
    dir_t               dir, dir_q;
    logic [9:0]         cam_x_q, cam_y_q, cam_x_d, cam_y_d;
    logic               key_l, key_r, key_u, key_dn, same;
    logic signed [10:0] step, nx, ny;

    function automatic logic [9:0] bound(input logic signed [10:0] v, input int lim);
`ifdef SCROLL_WRAP_EN
        return v < 0 ? 10'(v + 11'(lim)) : v >= 11'(lim) ? 10'(v - 11'(lim)) : v[9:0];
`else
        return v < 0 ? 10'd0 : v > 11'(lim) ? 10'(lim) : v[9:0];
`endif
    endfunction

    always_comb begin
        key_l   = keycode_i[7:0] == KEY_A || keycode_i[15:8] == KEY_A;
        key_r   = keycode_i[7:0] == KEY_D || keycode_i[15:8] == KEY_D;
        key_u   = keycode_i[7:0] == KEY_W || keycode_i[15:8] == KEY_W;
        key_dn  = keycode_i[7:0] == KEY_S || keycode_i[15:8] == KEY_S;
        dir.dx  = key_r == key_l ? 2'sd0 : key_r ? 2'sd1 : -2'sd1;
        dir.dy  = key_dn == key_u ? 2'sd0 : key_dn ? 2'sd1 : -2'sd1;
        same    = dir == dir_q;
        // fast stride only once FAST is already established for this direction
        step    = (state_q == CAM_FAST && same) ? 11'(FAST_STEP) : 11'(SLOW_STEP);
        nx      = $signed({1'b0, cam_x_q}) + (dir.dx == 2'sd1 ? step : dir.dx == -2'sd1 ? -step : 11'sd0);
        ny      = $signed({1'b0, cam_y_q}) + (dir.dy == 2'sd1 ? step : dir.dy == -2'sd1 ? -step : 11'sd0);
        cam_x_d = bound(nx, LIM_X);
        cam_y_d = bound(ny, LIM_Y);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CAM_IDLE;
            cnt_q   <= '0;
            dir_q   <= '0;
            cam_x_q <= '0;
            cam_y_q <= '0;
        end else if (tick_i) begin
            dir_q <= dir;
            if (dir == '0) begin
                state_q <= CAM_IDLE;
                cnt_q   <= '0;
            end else begin
                cam_x_q <= cam_x_d;
                cam_y_q <= cam_y_d;
                if (state_q == CAM_IDLE || !same) begin
                    state_q <= CAM_SLOW;
                    cnt_q   <= CW'(1);
                end else if (state_q == CAM_SLOW) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(HOLD_FRAMES - 1)) state_q <= CAM_FAST;
                end
            end
        end
    end

    assign cam_x_o = cam_x_q;
    assign cam_y_o = cam_y_q;
endmodule

// File: rtl/scroll_viewport_renderer.sv
// scroll_viewport_renderer: frame tick, window-to-map-ROM address pipeline and palette colour stage.
// SCROLL_WRAP_EN makes the view tile across the map edges instead of clamping the camera.
module scroll_viewport_renderer
    import viewport_pkg::*;
#(
    parameter int MAP_W       = 480,
    parameter int MAP_H       = 320,
    parameter int VIEW_W      = 240,
    parameter int VIEW_H      = 160,
    parameter int SCALE_LOG2  = 1,
    parameter int WIN_X0      = 80,
    parameter int WIN_Y0      = 80,
    parameter int SLOW_STEP   = 1,
    parameter int FAST_STEP   = 4,
    parameter int HOLD_FRAMES = 16,
    parameter int ROM_LAT     = 1,
    parameter int IDX_W       = 4,
    parameter int ADDR_W      = $clog2(MAP_W * MAP_H)
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [15:0]       keycode,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic [9:0]        CamX,
    output logic [9:0]        CamY
);
    localparam logic [9:0] X_END = 10'(WIN_X0 + (VIEW_W << SCALE_LOG2));
    localparam logic [9:0] Y_END = 10'(WIN_Y0 + (VIEW_H << SCALE_LOG2));

    logic              tick_q, in_win, on;
    logic [10:0]       mx, my;
    logic [ADDR_W-1:0] rom_address_d, rom_address_q;
    logic [ROM_LAT:0]  win_q, blank_q;
    logic [7:0]        red_q, green_q, blue_q;
    // the palette lookup happens outside; the index itself is not needed here
    logic              unused_rom;

    assign unused_rom = ^rom_q;

    viewport_camera #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .VIEW_W(VIEW_W), .VIEW_H(VIEW_H),
        .SLOW_STEP(SLOW_STEP), .FAST_STEP(FAST_STEP), .HOLD_FRAMES(HOLD_FRAMES)
    ) u_cam (
        .clk_i(vga_clk), .rst_i(Reset), .tick_i(tick_q), .keycode_i(keycode),
        .cam_x_o(CamX), .cam_y_o(CamY)
    );

    always_comb begin
        in_win = DrawX >= 10'(WIN_X0) && DrawX < X_END && DrawY >= 10'(WIN_Y0) && DrawY < Y_END;
        mx     = {1'b0, CamX} + {1'b0, (DrawX - 10'(WIN_X0)) >> SCALE_LOG2};
        my     = {1'b0, CamY} + {1'b0, (DrawY - 10'(WIN_Y0)) >> SCALE_LOG2};
`ifdef SCROLL_WRAP_EN
        mx     = mx >= 11'(MAP_W) ? mx - 11'(MAP_W) : mx;
        my     = my >= 11'(MAP_H) ? my - 11'(MAP_H) : my;
`endif
        rom_address_d = in_win ? ADDR_W'(my) * ADDR_W'(MAP_W) + ADDR_W'(mx) : '0;
        on     = blank_q[ROM_LAT] && win_q[ROM_LAT];
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            tick_q        <= 1'b0;
            rom_address_q <= '0;
            win_q         <= '0;
            blank_q       <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            tick_q        <= DrawX == '0 && DrawY == '0;
            rom_address_q <= rom_address_d;
            win_q         <= {win_q[ROM_LAT-1:0], in_win};
            blank_q       <= {blank_q[ROM_LAT-1:0], blank};
            red_q         <= on ? {pal_red, pal_red} : '0;
            green_q       <= on ? {pal_green, pal_green} : '0;
            blue_q        <= on ? {pal_blue, pal_blue} : '0;
        end
    end

    assign rom_address = rom_address_q;
    assign Red         = red_q;
    assign Green       = green_q;
    assign Blue        = blue_q;
endmodule

// File: tb/tb_scroll_viewport_renderer.sv
// tb_scroll_viewport_renderer: directed vectors and hand sequences for the scrolling viewport renderer.
module tb_scroll_viewport_renderer;
    import viewport_pkg::*;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        b;
        logic [17:0] addr;
        logic        on;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, blank = 1'b1, rom_force = 1'b0;
    logic [9:0]  draw_x = '0, draw_y = '0, cam_x, cam_y;
    logic [15:0] keycode = '0;
    logic [17:0] rom_address;
    logic [3:0]  rom_q = '0, pal_r, pal_g, pal_b;
    logic [7:0]  red, green, blue;
    int          n_cmp = 0, n_bad = 0;
    vec_t        v[10];
    int          exp_hold[20];

    scroll_viewport_renderer dut (
        .vga_clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .keycode(keycode), .rom_address(rom_address), .rom_q(rom_q),
        .pal_red(pal_r), .pal_green(pal_g), .pal_blue(pal_b),
        .Red(red), .Green(green), .Blue(blue), .CamX(cam_x), .CamY(cam_y)
    );

    always #5 clk = ~clk;

    // external map ROM (one cycle latency) and palette
    always @(posedge clk) rom_q <= rom_force ? 4'hF : rom_address[3:0] ^ rom_address[7:4];
    assign pal_r = rom_q;
    assign pal_g = ~rom_q;
    assign pal_b = rom_q ^ 4'h7;

    function automatic logic [23:0] px(input logic [17:0] a);
        logic [3:0] n;
        n = a[3:0] ^ a[7:4];
        return {n, n, ~n, ~n, n ^ 4'h7, n ^ 4'h7};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic frame();
        @(negedge clk);
        draw_x = '0;
        draw_y = '0;
        @(negedge clk);
        draw_x = 10'd5;
        draw_y = 10'd5;
        @(negedge clk);
    endtask

    task automatic do_reset();
        keycode = '0;
        @(negedge clk);
        rst    = 1'b1;
        draw_x = 10'd5;
        draw_y = 10'd5;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        v[0] = '{10'd80,  10'd81,  1'b1, 18'd0,     1'b1};
        v[1] = '{10'd82,  10'd82,  1'b1, 18'd481,   1'b1};
        v[2] = '{10'd79,  10'd100, 1'b1, 18'd0,     1'b0};
        v[3] = '{10'd100, 10'd100, 1'b0, 18'd4810,  1'b0};
        v[4] = '{10'd559, 10'd399, 1'b1, 18'd76559, 1'b1};
        v[5] = '{10'd560, 10'd100, 1'b1, 18'd0,     1'b0};
        v[6] = '{10'd80,  10'd400, 1'b1, 18'd0,     1'b0};
        v[7] = '{10'd81,  10'd80,  1'b1, 18'd0,     1'b1};
        v[8] = '{10'd200, 10'd300, 1'b1, 18'd52860, 1'b1};
        v[9] = '{10'd83,  10'd79,  1'b1, 18'd0,     1'b0};
        exp_hold = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 20, 24, 28, 32};

        // reset released at the raster origin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_camx", 32'(cam_x), 32'd0);
        chk("rst_camy", 32'(cam_y), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_addr", 32'(rom_address), 32'd0);
        draw_x = 10'd5;
        draw_y = 10'd5;
        @(negedge clk);
        chk("rst_state", 32'(dut.u_cam.state_q), 32'(CAM_IDLE));
        chk("rst_cnt", 32'(dut.u_cam.cnt_q), 32'd0);

        // acceleration: 16 slow frames then fast
        keycode = 16'h0007;
        for (int i = 0; i < 20; i++) begin
            frame();
            chk("hold_camx", 32'(cam_x), 32'(exp_hold[i]));
        end
        chk("hold_state", 32'(dut.u_cam.state_q), 32'(CAM_FAST));

        // key change between ticks does nothing
        keycode = 16'h0004;
        repeat (4) @(negedge clk);
        chk("midframe_camx", 32'(cam_x), 32'd32);
        keycode = 16'h0000;
        frame();
        chk("release_camx", 32'(cam_x), 32'd32);
        chk("release_state", 32'(dut.u_cam.state_q), 32'(CAM_IDLE));

        // right and bottom clamps
        keycode = 16'h0007;
        repeat (80) frame();
        chk("clamp_right", 32'(cam_x), 32'd240);
        keycode = 16'h0016;
        repeat (60) frame();
        chk("clamp_bottom", 32'(cam_y), 32'd160);
        chk("clamp_bottom_x", 32'(cam_x), 32'd240);

        // left and top clamps
        do_reset();
        keycode = 16'h0004;
        frame();
        chk("clamp_left", 32'(cam_x), 32'd0);
        keycode = 16'h001A;
        frame();
        chk("clamp_top", 32'(cam_y), 32'd0);

        // diagonal and cancelling keys
        do_reset();
        keycode = 16'h1607;
        repeat (10) frame();
        chk("diag_x10", 32'(cam_x), 32'd10);
        chk("diag_y10", 32'(cam_y), 32'd10);
        keycode = 16'h1A07;
        frame();
        chk("wd_camx", 32'(cam_x), 32'd11);
        chk("wd_camy", 32'(cam_y), 32'd9);
        chk("wd_state", 32'(dut.u_cam.state_q), 32'(CAM_SLOW));
        keycode = 16'h0704;
        frame();
        chk("ad_camx", 32'(cam_x), 32'd11);
        chk("ad_camy", 32'(cam_y), 32'd9);
        chk("ad_state", 32'(dut.u_cam.state_q), 32'(CAM_IDLE));
        keycode = 16'h0000;

        // addressing with a nonzero camera
        draw_x = 10'd80;
        draw_y = 10'd80;
        @(negedge clk);
        chk("cam_addr0", 32'(rom_address), 32'd4331);
        draw_x = 10'd559;
        draw_y = 10'd399;
        @(negedge clk);
        chk("cam_addr1", 32'(rom_address), 32'd80890);

        // streamed vectors at camera origin: address after 1 cycle, colour after 3
        do_reset();
        for (int j = 0; j < 13; j++) begin
            @(negedge clk);
            if (j >= 1 && j <= 10) chk("vec_addr", 32'(rom_address), 32'(v[j-1].addr));
            if (j >= 3) chk("vec_rgb", 32'({red, green, blue}), v[j-3].on ? 32'(px(v[j-3].addr)) : 32'd0);
            if (j < 10) begin
                draw_x = v[j].x;
                draw_y = v[j].y;
                blank  = v[j].b;
            end else begin
                draw_x = 10'd5;
                draw_y = 10'd5;
                blank  = 1'b1;
            end
        end

        // exact latency with a full-scale palette entry
        rom_force = 1'b1;
        @(negedge clk);
        draw_x = 10'd82;
        draw_y = 10'd82;
        @(negedge clk);
        chk("lat_addr", 32'(rom_address), 32'd481);
        draw_x = 10'd79;
        @(negedge clk);
        chk("lat_early", 32'({red, green, blue}), 32'd0);
        @(negedge clk);
        chk("lat_rgb", 32'({red, green, blue}), 32'hFF0088);
        @(negedge clk);
        chk("lat_outside", 32'({red, green, blue}), 32'd0);

        // asynchronous reset mid-line
        keycode = 16'h0007;
        repeat (3) frame();
        keycode = 16'h0000;
        chk("pre_rst_camx", 32'(cam_x), 32'd3);
        draw_x = 10'd82;
        draw_y = 10'd82;
        repeat (4) @(negedge clk);
        chk("pre_rst_rgb", 32'({red, green, blue}), 32'hFF0088);
        #2 rst = 1'b1;
        #1;
        chk("midline_rgb", 32'({red, green, blue}), 32'd0);
        chk("midline_camx", 32'(cam_x), 32'd0);
        chk("midline_addr", 32'(rom_address), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rom_force = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
